key_debounce_bank: RTL



---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_channel.sv | 118 +++++++++++
 rtl/key_debounce_bank.sv | 55 +++++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the key debounce bank.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DB_DN = 2'd1,
        DOWN  = 2'd2,
        DB_UP = 2'd3
    } kstate_t;

    localparam int DCNT_W = 8;

    // Clock cycles per 1 ms tick; never below one so tiny test clocks still tick.
    function automatic int tick_div(input int clk_hz);
        return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
    endfunction

    // Bits needed to hold 0..max_val (at least one).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-FF synchroniser, debounce FSM, long-press counter; all outputs registered.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam logic              REL   = (ACTIVE_LOW != 0);
    localparam logic [DCNT_W-1:0] DEB_V = DCNT_W'(DEBOUNCE_MS);

    logic [1:0]        sync_q;
    logic              kp;
    kstate_t           state;
    logic [DCNT_W-1:0] dcnt;
    logic              press_acc;
    logic              down_tick;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) sync_q <= {2{REL}};
        else       sync_q <= {sync_q[0], key_in};
    end

    assign kp = sync_q[1] ^ REL;

    // A kp change always takes priority over a coincident tick.
    assign press_acc = (state == DB_DN) && kp && tick && (dcnt == DEB_V - 1'b1);
    assign down_tick = (state == DOWN) && kp && tick;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= UP;
            dcnt          <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                UP: begin
                    if (kp) begin
                        state <= DB_DN;
                        dcnt  <= '0;
                    end
                end
                DB_DN: begin
                    if (!kp) begin
                        state <= UP;
                    end else if (tick) begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DEB_V - 1'b1) begin
                            state       <= DOWN;
                            key_level   <= 1'b1;
                            press_pulse <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (!kp) begin
                        state <= DB_UP;
                        dcnt  <= '0;
                    end
                end
                DB_UP: begin
                    if (kp) begin
                        state <= DOWN;
                    end else if (tick) begin
                        dcnt <= dcnt + 1'b1;
                        if (dcnt == DEB_V - 1'b1) begin
                            state         <= UP;
                            key_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end
                    end
                end
                default: state <= UP;
            endcase
        end
    end

    generate
        if (LONG_MS > 0) begin : g_long
            localparam int            LW     = cnt_w(LONG_MS);
            localparam logic [LW-1:0] LONG_V = LW'(LONG_MS);
            logic [LW-1:0] lcnt;

            // Hold time survives rejected release glitches; only a new press clears it.
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    lcnt       <= '0;
                    long_pulse <= 1'b0;
                end else begin
                    long_pulse <= 1'b0;
                    if (press_acc) begin
                        lcnt <= '0;
                    end else if (down_tick && lcnt != LONG_V) begin
                        lcnt <= lcnt + 1'b1;
                        if (lcnt == LONG_V - 1'b1) long_pulse <= 1'b1;
                    end
                end
            end
        end else begin : g_nolong
            assign long_pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/key_debounce_bank.sv
// N-channel key debouncer: shared 1 ms prescaler feeding one debounce channel per key.
module key_debounce_bank
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse
);

    localparam int            DIV   = tick_div(CLK_HZ);
    localparam int            PW    = cnt_w(DIV - 1);
    localparam logic [PW-1:0] LAST  = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    // Free-running; channels never restart it, hence the partial first tick.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)             pcnt <= '0;
        else if (pcnt == LAST) pcnt <= '0;
        else                   pcnt <= pcnt + 1'b1;
    end

    assign tick = (pcnt == LAST);

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
            key_debounce_channel #(
                .DEBOUNCE_MS (DEBOUNCE_MS),
                .LONG_MS     (LONG_MS),
                .ACTIVE_LOW  (ACTIVE_LOW)
            ) u_ch (
                .CLK           (CLK),
                .RSTn          (RSTn),
                .tick          (tick),
                .key_in        (key_in[i]),
                .key_level     (key_level[i]),
                .press_pulse   (press_pulse[i]),
                .release_pulse (release_pulse[i]),
                .long_pulse    (long_pulse[i])
            );
        end
    endgenerate

endmodule
